uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter Data_Width, default 8, payload bits per frame.
REQ-002 SHALL have parameter OverSampling, default 16, clk cycles per bit period (even, >=4).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port parity_en  input  1  1 = frame carries a parity bit after data.
REQ-007 SHALL have port parity_type  input  1  0 even, 1 odd.
REQ-008 SHALL have port data_out  output  Data_Width  received payload, LSB received first.
REQ-009 SHALL have port rx_valid  output  1  data_out/error flags hold a frame.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts frame when high with rx_valid.
REQ-011 SHALL have port parity_error  output  1  parity mismatch for held frame.
REQ-012 SHALL have port framing_error  output  1  stop bit sampled low for held frame.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse, completed frame dropped.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer (rx_sync); all logic uses rx_sync only.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; clk_count and bit_index cleared in IDLE.
REQ-016 IDLE SHALL go to START on a falling edge of rx_sync (previous 1, current 0); a line held low SHALL NOT start a frame.
REQ-017 START SHALL sample rx_sync at clk_count == OverSampling/2-1: 0 -> DATA with clk_count cleared; 1 -> IDLE (glitch rejected, nothing reported).
REQ-018 DATA SHALL sample at clk_count == OverSampling-1 (bit centre), shift sample into MSB of shift register, increment bit_index; after Data_Width samples -> PARITY if parity_en else STOP.
REQ-019 parity_en and parity_type SHALL be captured on leaving IDLE and held for the frame.
REQ-020 PARITY SHALL sample at clk_count == OverSampling-1; error when data XOR parity bit XOR parity_type is 1; -> STOP.
REQ-021 STOP SHALL sample at clk_count == OverSampling-1; sample 0 sets framing error; -> IDLE in the same cycle.
REQ-022 Frame completion SHALL update data_out, parity_error, framing_error and assert rx_valid on the clock edge after the stop sample, if rx_valid is 0 or rx_ready is 1 in the stop-sample cycle.
REQ-023 rx_valid SHALL stay high, with outputs stable, until a cycle with rx_ready high; then drop next cycle unless REQ-022 reloads it in that same cycle.
REQ-024 Completion while rx_valid=1 and rx_ready=0 SHALL discard the new frame, keep held outputs, and pulse overrun for one cycle.
REQ-025 Frame reception SHALL continue independent of rx_ready (no back-pressure on the line).

Reset
REQ-026 reset low SHALL immediately force IDLE, counters 0, data_out 0, rx_valid 0, parity_error 0, framing_error 0, overrun 0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, the next falling edge starts a fresh frame.

Structure
REQ-028 Package uart_pkg SHALL hold the rx state typedef and parity constants PARITY_EVEN=0, PARITY_ODD=1.
REQ-029 Synchronizer SHALL be sub-module uart_rx_sync (reset value 1); the rest is flat in uart_rx.

Verification
REQ-030 8N1, OverSampling 16, frame 0xA5, rx_ready=1 -> data_out 0xA5, rx_valid one cycle, no errors.
REQ-031 parity_en=1 parity_type=0, 0x07 with parity bit 1 -> valid, parity_error 0; parity bit 0 -> parity_error 1.
REQ-032 0x3C with stop bit 0 -> framing_error 1; line held low afterwards -> no further frame until a rising then falling edge.
REQ-033 Low pulse of 4 clk on idle line -> no rx_valid, FSM back in IDLE.
REQ-034 rx_ready=0, frames 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once; raising rx_ready -> rx_valid drops.
REQ-035 reset asserted during bit 3 of 0x55, then full 0x99 frame -> only 0x99 reported.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared receiver state type and parity-sense constants for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_sync
);

  logic meta;

  // NOTE: both flops use non-blocking assignments so each stage captures the previous
  // stage's old value; blocking here would collapse the pair into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx;
      rx_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity, valid/ready output hold and overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_Width   = 8,
  parameter int OverSampling = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic [Data_Width-1:0] data_out,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int CW = $clog2(OverSampling);
  localparam int BW = $clog2(Data_Width + 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(OverSampling / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OverSampling - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(Data_Width - 1);

  rx_state_t             state;
  logic                  rx_sync;
  logic                  rx_prev;
  logic [CW-1:0]         clk_count;
  logic [BW-1:0]         bit_index;
  logic [Data_Width-1:0] shift;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  par_err_q;
  logic                  at_sample;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_sync (rx_sync)
  );

  assign at_sample = (clk_count == LAST_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rx_prev       <= 1'b1;
      clk_count     <= '0;
      bit_index     <= '0;
      shift         <= '0;
      par_en_q      <= 1'b0;
      par_type_q    <= PARITY_EVEN;
      par_err_q     <= 1'b0;
      data_out      <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_prev <= rx_sync;
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state == DATA || state == PARITY || state == STOP)
        clk_count <= at_sample ? '0 : clk_count + 1'b1;

      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          par_err_q <= 1'b0;
          // Only a 1->0 transition starts a frame; a line stuck low stays idle.
          if (rx_prev && !rx_sync) begin
            state      <= START;
            par_en_q   <= parity_en;
            par_type_q <= parity_type ? PARITY_ODD : PARITY_EVEN;
          end
        end

        START: begin
          if (clk_count == HALF_TICK) begin
            clk_count <= '0;
            state     <= rx_sync ? IDLE : DATA;
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

        DATA: begin
          if (at_sample) begin
            shift     <= Data_Width'({rx_sync, shift} >> 1);
            bit_index <= bit_index + 1'b1;
            if (bit_index == LAST_BIT) begin
              bit_index <= '0;
              state     <= par_en_q ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (at_sample) begin
            par_err_q <= (^shift) ^ rx_sync ^ (par_type_q == PARITY_ODD);
            state     <= STOP;
          end
        end

        STOP: begin
          if (at_sample) begin
            state <= IDLE;
            // A still-unconsumed frame wins; the new one is dropped and flagged.
            if (!rx_valid || rx_ready) begin
              data_out      <= shift;
              parity_error  <= par_err_q;
              framing_error <= !rx_sync;
              rx_valid      <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame-level bench for uart_rx: a queue of expected frames is built from the bits sent.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_type = 1'b0;
  logic          rx_ready = 1'b1;
  logic [DW-1:0] data_out;
  logic          rx_valid;
  logic          parity_error;
  logic          framing_error;
  logic          overrun;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cycles = 0;
  int ovr_seen = 0;
  int exp_ovr = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] last_seen = '0;

  uart_rx #(.Data_Width(DW), .OverSampling(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle a frame is held it must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset) begin
      if (overrun) ovr_seen++;
      if (rx_valid) begin
        valid_cycles++;
        last_seen = {data_out, parity_error, framing_error};
        check("frame_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("frame", {data_out, parity_error, framing_error}, exp_q[0]);
      end
    end
  end

  always @(posedge clk) begin
    if (reset && rx_valid && rx_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // Model: a completed frame is kept unless an unconsumed frame is already held.
  task automatic model_frame(input logic [DW-1:0] d, input logic perr, input logic ferr);
    if (!rx_ready && exp_q.size() > 0) exp_ovr++;
    else exp_q.push_back({d, perr, ferr});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic flip_par, input logic stop_bit);
    logic par_bit;
    parity_en   = pe;
    parity_type = pt;
    drive_bit(1'b0);
    parity_en   = 1'($urandom);
    parity_type = 1'($urandom);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    par_bit = (^d) ^ pt ^ flip_par;
    if (pe) drive_bit(par_bit);
    model_frame(d, pe & flip_par, ~stop_bit);
    drive_bit(stop_bit);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ovr_base;
    logic [DW-1:0] d;
    logic pe, pt, flip, stop;

    @(negedge clk);
    check("reset_data_out", data_out, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_parity_error", parity_error, 0);
    check("reset_framing_error", framing_error, 0);
    check("reset_overrun", overrun, 0);
    idle(3);
    reset = 1'b1;
    idle(5);

    base = valid_cycles;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    idle(2 * OS);
    check("a5_valid_one_cycle", valid_cycles - base, 1);
    check("a5_literal", last_seen, {8'hA5, 2'b00});

    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    idle(OS);
    check("even_parity_ok", last_seen, {8'h07, 2'b00});
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    rx = 1'b1;
    idle(OS);
    check("even_parity_bad", last_seen, {8'h07, 2'b10});
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    rx = 1'b1;
    idle(OS);
    check("odd_parity_ok", last_seen, {8'h07, 2'b00});

    base = valid_cycles;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6 * OS);
    check("framing_literal", last_seen, {8'h3C, 2'b01});
    check("held_low_no_frame", valid_cycles - base, 1);
    rx = 1'b1;
    idle(OS);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    idle(OS);
    check("after_low_literal", last_seen, {8'h5A, 2'b00});

    base = valid_cycles;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * OS);
    check("glitch_no_valid", valid_cycles - base, 0);
    check("glitch_idle", dut.state == IDLE, 1);

    ovr_base = ovr_seen;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    idle(OS);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    idle(2 * OS);
    check("overrun_held_data", data_out, 8'h11);
    check("overrun_held_valid", rx_valid, 1);
    check("overrun_one_pulse", ovr_seen - ovr_base, 1);
    rx_ready = 1'b1;
    idle(1);
    check("ready_drops_valid", rx_valid, 0);

    parity_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    idle(OS / 2);
    reset = 1'b0;
    idle(1);
    check("midreset_data_out", data_out, 0);
    check("midreset_valid", rx_valid, 0);
    check("midreset_flags", {parity_error, framing_error, overrun}, 0);
    check("midreset_state", dut.state == IDLE, 1);
    rx = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(OS);
    base = valid_cycles;
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    idle(2 * OS);
    check("after_reset_literal", last_seen, {8'h99, 2'b00});
    check("after_reset_one_frame", valid_cycles - base, 1);

    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      rx_ready = ($urandom_range(0, 2) != 0);
      send_frame(d, pe, pt, flip, stop);
      rx = 1'b1;
      idle(stop ? $urandom_range(0, 2 * OS) : $urandom_range(2, 2 * OS));
    end

    rx_ready = 1'b1;
    rx = 1'b1;
    idle(4 * OS);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_count", ovr_seen, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
